// File: rtl/key_expand_if.sv
// Handshake and read-port bundle for the AES-128 key expander.
interface key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  modport master (
    output start, key_in, rd_idx,
    input  busy, rk_valid, rk_idx, round_key, done, rd_key
  );

  modport slave (
    input  start, key_in, rd_idx,
    output busy, rk_valid, rk_idx, round_key, done, rd_key
  );
endinterface

// File: rtl/key_expand.sv
// AES-128 key expander: one round key per cycle, rounds 0..10.
// Define KEY_EXPAND_STORE_EN to keep all 11 round keys readable via rd_idx/rd_key.
module aes_sbox (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);
  // Entry 0 sits in the leftmost byte so the ascending range indexes naturally.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign byte_out = SBOX[{byte_in, 3'b000} +: 8];
endmodule

module key_expand (
  input logic         clk,
  input logic         rst,
  key_expand_if.slave bus
);
  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state;
  logic [127:0] round_key_r;
  logic [3:0]   rk_idx_r;
  logic         busy_r;
  logic         rk_valid_r;
  logic         done_r;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_rot;
  logic [31:0]  t, n0, n1, n2, n3;
  logic [7:0]   rcon;

  assign {w0, w1, w2, w3} = round_key_r;

  // RotWord is folded into the S-box wiring: byte order {w3[23:0], w3[31:24]}.
  aes_sbox u_sbox3 (.byte_in(w3[23:16]), .byte_out(sub_rot[31:24]));
  aes_sbox u_sbox2 (.byte_in(w3[15:8]),  .byte_out(sub_rot[23:16]));
  aes_sbox u_sbox1 (.byte_in(w3[7:0]),   .byte_out(sub_rot[15:8]));
  aes_sbox u_sbox0 (.byte_in(w3[31:24]), .byte_out(sub_rot[7:0]));

  // Rcon for the round being produced, i.e. rk_idx + 1.
  always_comb begin
    rcon = 8'h00;
    case (rk_idx_r)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub_rot ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      round_key_r <= '0;
      rk_idx_r    <= '0;
      busy_r      <= 1'b0;
      rk_valid_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= EXPAND;
            round_key_r <= bus.key_in;
            rk_idx_r    <= 4'd0;
            busy_r      <= 1'b1;
            rk_valid_r  <= 1'b1;
            done_r      <= 1'b0;
          end
        end
        EXPAND: begin
          // Round 10 has just been presented; key and index stay visible while idle.
          if (rk_idx_r == 4'd10) begin
            state      <= IDLE;
            busy_r     <= 1'b0;
            rk_valid_r <= 1'b0;
            done_r     <= 1'b0;
          end else begin
            round_key_r <= {n0, n1, n2, n3};
            rk_idx_r    <= rk_idx_r + 4'd1;
            done_r      <= (rk_idx_r == 4'd9);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.rk_valid  = rk_valid_r;
  assign bus.rk_idx    = rk_idx_r;
  assign bus.round_key = round_key_r;
  assign bus.done      = done_r;

`ifdef KEY_EXPAND_STORE_EN
  logic [127:0] store [0:10];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else if (rk_valid_r) begin
      for (int i = 0; i < 11; i++)
        if (rk_idx_r == i[3:0]) store[i] <= round_key_r;
    end
  end

  // Indices 11..15 match no entry and read as zero.
  always_comb begin
    bus.rd_key = '0;
    for (int i = 0; i < 11; i++)
      if (bus.rd_idx == i[3:0]) bus.rd_key = store[i];
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^bus.rd_idx;
  assign bus.rd_key    = '0;
`endif
endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand against a FIPS-197 word-array reference model.
module tb_key_expand;
  logic clk = 1'b0;
  logic rst;
  int   compareCount  = 0;
  int   mismatchCount = 0;

  logic [7:0]   sboxModel [0:255];
  logic [127:0] expKeys   [0:10];

  key_expand_if bus ();

  key_expand dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from GF(2^8) inverse plus the affine map, not from a table.
  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sboxModel[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic computeModel(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sboxModel[temp[31:24]], sboxModel[temp[23:16]], sboxModel[temp[15:8]], sboxModel[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkRound(input int r, input bit fips);
    checkOutput($sformatf("busy_r%0d", r), bus.busy, 1);
    checkOutput($sformatf("valid_r%0d", r), bus.rk_valid, 1);
    checkOutput($sformatf("idx_r%0d", r), bus.rk_idx, r);
    checkOutput($sformatf("key_r%0d", r), bus.round_key, expKeys[r]);
    checkOutput($sformatf("done_r%0d", r), bus.done, (r == 10));
    if (fips && r == 1) checkOutput("fips_rk1", bus.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    if (fips && r == 10) checkOutput("fips_rk10", bus.round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  task automatic checkStore(input bit expectZero);
    logic [127:0] exp;
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = i[3:0];
      #1;
`ifdef KEY_EXPAND_STORE_EN
      exp = (expectZero || i > 10) ? 128'h0 : expKeys[i];
`else
      exp = 128'h0;
`endif
      checkOutput($sformatf("rd_key_%0d", i), bus.rd_key, exp);
    end
  endtask

  // One expansion; optionally pulse start (key 0) at injectAt or assert rst at abortAt.
  task automatic applyStimulus(input logic [127:0] key, input int injectAt, input int abortAt, input bit fips);
    computeModel(key);
    @(negedge clk);
    checkOutput("pre_idle_busy", bus.busy, 0);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      checkRound(r, fips);
      if (r == abortAt) begin
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_valid", bus.rk_valid, 0);
        checkOutput("abort_idx", bus.rk_idx, 0);
        checkOutput("abort_key", bus.round_key, 0);
        checkOutput("abort_done", bus.done, 0);
        @(negedge clk);
        checkOutput("abort_stay_idle", bus.busy, 0);
        checkStore(1'b1);
        return;
      end
      if (r == injectAt) begin
        bus.start  = 1'b1;
        bus.key_in = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("post_busy", bus.busy, 0);
    checkOutput("post_valid", bus.rk_valid, 0);
    checkOutput("post_done", bus.done, 0);
    checkOutput("post_idx_hold", bus.rk_idx, 10);
    checkOutput("post_key_hold", bus.round_key, expKeys[10]);
    checkStore(1'b0);
  endtask

  // Start held high across two expansions; key_in changes while busy and must be sampled only at the idle cycle.
  task automatic applyBackToBack(input logic [127:0] keyA, input logic [127:0] keyB);
    computeModel(keyA);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = keyA;
    @(negedge clk);
    bus.key_in = keyB;
    for (int r = 0; r <= 10; r++) begin
      checkRound(r, 1'b0);
      @(negedge clk);
    end
    checkOutput("b2b_gap_busy", bus.busy, 0);
    checkOutput("b2b_gap_valid", bus.rk_valid, 0);
    computeModel(keyB);
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      checkRound(r, 1'b0);
      @(negedge clk);
    end
    checkOutput("b2b_end_busy", bus.busy, 0);
  endtask

  function automatic logic [127:0] randKey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.rd_idx = '0;
    buildSbox();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_valid", bus.rk_valid, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_idx", bus.rk_idx, 0);
    checkOutput("rst_key", bus.round_key, 0);
    rst = 1'b0;
    checkStore(1'b1);

    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, -1, 1'b1);
    bus.rd_idx = 4'd1;  #1; checkOutput("fips_rd1", bus.rd_key,
`ifdef KEY_EXPAND_STORE_EN
      128'ha0fafe1788542cb123a339392a6c7605);
`else
      128'h0);
`endif
    applyStimulus(randKey(), 4, -1, 1'b0);
    applyStimulus(randKey(), 10, -1, 1'b0);
    applyStimulus(randKey(), -1, 5, 1'b0);
    applyStimulus(randKey(), -1, -1, 1'b0);
    applyBackToBack(randKey(), randKey());
    for (int n = 0; n < 3; n++) applyStimulus(randKey(), -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
